// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared state type, width default and round-robin pick helper for counter_scheduler
package counter_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;
  localparam int WIDTH_DEF = 5;
  localparam int MAX_REQ = 32;
  // One-hot grant of the first set bit of valid searching upward from last+1, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input int last, input int n);
    logic [MAX_REQ-1:0] g;
    logic [4:0] idx;
    g = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 5'((last + k) % n);
      if (k <= n && g == '0 && valid[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a last-grant pointer updated on accept
// Ports: clock, reset (sync, active-high), req_valid[NUM_REQ], accept (commit grant),
//        grant[NUM_REQ] (one-hot, combinational), grant_id[ID_W] (index of grant).
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);
  logic [ID_W-1:0] last_q, last_d;
  always_comb begin
    grant = NUM_REQ'(rr_pick(MAX_REQ'(req_valid), int'(last_q), NUM_REQ));
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_id = grant[i] ? ID_W'(i) : grant_id;
    last_d = accept ? grant_id : last_q;
  end
  // Pointer starts at the top so requester 0 wins the first arbitration.
  always_ff @(posedge clock) last_q <= reset ? ID_W'(NUM_REQ - 1) : last_d;
endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: time-shares one external free-running counter among NUM_REQ requesters
// Ports: clock, reset (sync, active-high); req_valid/req_len/req_ready request side
//        (len slice i = req_len[i*WIDTH +: WIDTH], ready one-hot, IDLE only);
//        ctr_reset/ctr_count counter side; busy (RUN or DONE);
//        done_valid/done_id one-cycle registered completion.
// Optional COUNTER_SCHED_ABORT_EN adds abort (in) and done_aborted (out).
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = WIDTH_DEF,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     ctr_reset,
  input  logic [WIDTH-1:0]         ctr_count,
`ifdef COUNTER_SCHED_ABORT_EN
  input  logic                     abort,
  output logic                     done_aborted,
`endif
  output logic                     busy,
  output logic                     done_valid,
  output logic [ID_W-1:0]          done_id
);
  sched_state_t state_q, state_d;
  logic [WIDTH-1:0] len_q, len_d, len_sel;
  logic [ID_W-1:0] id_q, id_d, done_id_q, done_id_d, grant_id;
  logic done_valid_q, done_valid_d;
  logic [NUM_REQ-1:0] grant;
  logic accept, match, abort_hit;
`ifdef COUNTER_SCHED_ABORT_EN
  logic done_aborted_q, done_aborted_d;
  // A match in the same cycle takes precedence over abort.
  assign abort_hit = abort && !match;
  assign done_aborted = done_aborted_q;
`else
  assign abort_hit = 1'b0;
`endif
  assign accept = state_q == IDLE && |req_valid && !reset;
  assign match = ctr_count == len_q;
  assign req_ready = accept ? grant : '0;
  assign busy = state_q != IDLE;
  assign ctr_reset = reset || state_q != RUN;
  assign done_valid = done_valid_q;
  assign done_id = done_id_q;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .accept(accept),
    .grant(grant),
    .grant_id(grant_id)
  );
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) len_sel = grant[i] ? req_len[i*WIDTH +: WIDTH] : len_sel;
    state_d = state_q;
    len_d = len_q;
    id_d = id_q;
    done_valid_d = 1'b0;
    done_id_d = done_id_q;
`ifdef COUNTER_SCHED_ABORT_EN
    done_aborted_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        state_d = accept ? RUN : IDLE;
        len_d = accept ? len_sel : len_q;
        id_d = accept ? grant_id : id_q;
      end
      RUN: begin
        state_d = (match || abort_hit) ? DONE : RUN;
        done_valid_d = match || abort_hit;
        done_id_d = (match || abort_hit) ? id_q : done_id_q;
`ifdef COUNTER_SCHED_ABORT_EN
        done_aborted_d = abort_hit;
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      id_q <= '0;
      done_valid_q <= 1'b0;
      done_id_q <= '0;
`ifdef COUNTER_SCHED_ABORT_EN
      done_aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      id_q <= id_d;
      done_valid_q <= done_valid_d;
      done_id_q <= done_id_d;
`ifdef COUNTER_SCHED_ABORT_EN
      done_aborted_q <= done_aborted_d;
`endif
    end
  end
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed self-checking bench for counter_scheduler with a behavioural counter
module tb_counter_scheduler;
  localparam int N = 4;
  localparam int W = 5;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_len = '0;
  logic [N-1:0] req_ready;
  logic ctr_reset;
  logic [W-1:0] ctr_count;
  logic busy, done_valid;
  logic [1:0] done_id;
`ifdef COUNTER_SCHED_ABORT_EN
  logic abort = 1'b0;
  logic done_aborted;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  always_ff @(posedge clock) ctr_count <= ctr_reset ? '0 : ctr_count + 1'b1;
  counter_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_len(req_len),
    .req_ready(req_ready),
    .ctr_reset(ctr_reset),
    .ctr_count(ctr_count),
`ifdef COUNTER_SCHED_ABORT_EN
    .abort(abort),
    .done_aborted(done_aborted),
`endif
    .busy(busy),
    .done_valid(done_valid),
    .done_id(done_id)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask
  // Called in an IDLE cycle; accepts, follows the run, and returns in the next accept cycle.
  task automatic run_len(input int id, input int len, input logic [N-1:0] valid, input logic hold);
    req_valid = valid;
    #1;
    check("ready", req_ready, 32'(1 << id));
    check("busy_idle", busy, 0);
    for (int k = 1; k <= len + 2; k++) begin
      next_cycle();
      if (!hold) req_valid = '0;
      #1;
      check("busy", busy, 1);
      check("ready_busy", req_ready, 0);
      check("done_valid", done_valid, 32'(k == len + 2));
      check("ctr_reset", ctr_reset, 32'(k == len + 2));
      if (k <= len + 1) check("count", ctr_count, k - 1);
      else check("done_id", done_id, id);
`ifdef COUNTER_SCHED_ABORT_EN
      if (k == len + 2) check("done_aborted_match", done_aborted, 0);
`endif
    end
    next_cycle();
    #1;
    check("done_drop", done_valid, 0);
    check("busy_drop", busy, 0);
    check("ctr_reset_idle", ctr_reset, 1);
  endtask
  initial begin
    req_valid = '1;
    req_len = {5'd7, 5'd7, 5'd7, 5'd3};
    repeat (3) next_cycle();
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_ctr_reset", ctr_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_id", done_id, 0);
`ifdef COUNTER_SCHED_ABORT_EN
    check("rst_done_aborted", done_aborted, 0);
`endif
    reset = 1'b0;
    run_len(0, 3, 4'b0001, 1'b0);
    req_len[4:0] = 5'd0;
    run_len(0, 0, 4'b0001, 1'b0);
    req_len[14:10] = 5'd31;
    run_len(2, 31, 4'b0100, 1'b0);
    req_len[9:5] = 5'd10;
    req_valid = 4'b0010;
    #1;
    check("rst_run_ready", req_ready, 4'b0010);
    next_cycle();
    req_valid = '0;
    next_cycle();
    #1;
    check("rst_run_busy", busy, 1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_ctr_reset", ctr_reset, 1);
    check("post_rst_done", done_valid, 0);
    req_len = {4{5'd1}};
    run_len(0, 1, 4'b1111, 1'b1);
    run_len(1, 1, 4'b1111, 1'b1);
    run_len(2, 1, 4'b1111, 1'b1);
    run_len(3, 1, 4'b1111, 1'b1);
    run_len(0, 1, 4'b1111, 1'b1);
    req_valid = '0;
`ifdef COUNTER_SCHED_ABORT_EN
    next_cycle();
    req_len[4:0] = 5'd10;
    req_valid = 4'b0001;
    #1;
    check("ab_ready", req_ready, 4'b0001);
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();
    abort = 1'b1;
    #1;
    check("ab_busy", busy, 1);
    next_cycle();
    abort = 1'b0;
    #1;
    check("ab_done_valid", done_valid, 1);
    check("ab_done_aborted", done_aborted, 1);
    check("ab_done_id", done_id, 0);
    next_cycle();
    #1;
    check("ab_drop", done_valid, 0);
    check("ab_aborted_drop", done_aborted, 0);
    req_valid = 4'b0001;
    abort = 1'b1;
    #1;
    check("ab_idle_ready", req_ready, 4'b0001);
    for (int k = 1; k <= 11; k++) begin
      next_cycle();
      req_valid = '0;
      abort = (k == 11);
      #1;
      check("ab_count", ctr_count, k - 1);
      check("ab_no_done", done_valid, 0);
    end
    next_cycle();
    abort = 1'b0;
    #1;
    check("ab_match_done", done_valid, 1);
    check("ab_match_aborted", done_aborted, 0);
`endif
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
